// File: rtl/uart_pkg.sv
// Shared state encodings, error-flag layout, default sizing and BIST pattern for uart_sv.
package uart_pkg;
  localparam int SYSCLK_RATE_DEF = 4;
  localparam int BAUD_RATE_DEF   = 1;
  localparam int DATA_BITS_DEF   = 8;
  localparam int PARITY_BIT_DEF  = 1;
  localparam int STOP_BITS_DEF   = 2;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int DIV             = SYSCLK_RATE_DEF / BAUD_RATE_DEF;
  localparam int FRAME_BITS      = 1 + DATA_BITS_DEF + PARITY_BIT_DEF + STOP_BITS_DEF;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Sticky receive flags: bit 0 parity, bit 1 framing, bit 2 overrun.
  typedef struct packed {
    logic overrun;
    logic framing;
    logic parity;
  } rx_err_t;

  function automatic logic [7:0] bist_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h55;
      2'd1:    return 8'hAA;
      2'd2:    return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-time generator: one-cycle tick every DIV clocks, paces the transmitter.
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic gclk,
  input  logic grst_n,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
endmodule

// File: rtl/uart_sv.sv
// Full-duplex UART with Tx/Rx FIFOs, even parity, CTS/RTS flow control and loopback BIST.
module uart_sv
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = SYSCLK_RATE_DEF,
  parameter int BAUD_RATE   = BAUD_RATE_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int PARITY_BIT  = PARITY_BIT_DEF,
  parameter int STOP_BITS   = STOP_BITS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Wr_En,
  input  logic [DATA_BITS-1:0] Wr_Data,
  output logic                 Tx_Full,
  output logic                 FIFO_Empty,
  input  logic                 Rd_En,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  input  logic                 BIST_Start,
  output logic                 BIST_Busy,
  output logic                 BIST_Error,
  input  logic                 Rx,
  output logic                 Tx,
  input  logic                 CTS,
  output logic                 RTS
);
  localparam int BDIV = SYSCLK_RATE / BAUD_RATE;
  localparam int CW   = $clog2(BDIV);
  localparam int BW   = $clog2(DATA_BITS + STOP_BITS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int HALF = BDIV / 2 - 1;

  logic tick;
  uart_baud_gen #(.DIV(BDIV)) u_baud (.gclk(SysClk), .grst_n(Rst), .tick(tick));

  logic                 bist_busy, bist_err, bist_fin, bist_go, bist_pend;
  logic [2:0]           bist_txi;
  logic [1:0]           bist_rxi;
  tx_state_t            ts;
  logic                 tx_bit, tpar, tx_avail, tx_load;
  logic [DATA_BITS-1:0] tsh, tx_next;
  logic [BW-1:0]        tcnt;

  logic [DATA_BITS-1:0] tmem [FIFO_DEPTH];
  logic [AW:0]          twp, trp;
  logic                 tx_empty, tx_full, tpush, tpop;

  assign tx_empty = (twp == trp);
  assign tx_full  = (twp[AW] != trp[AW]) && (twp[AW-1:0] == trp[AW-1:0]);
  assign tpush    = Wr_En && (!tx_full || tpop);
  assign tpop     = tx_load && !bist_busy;

  always_ff @(posedge SysClk) if (tpush) tmem[twp[AW-1:0]] <= Wr_Data;

  always_ff @(posedge SysClk or negedge Rst)
    if (!Rst) begin
      twp <= '0;
      trp <= '0;
    end else begin
      if (tpush) twp <= twp + (AW+1)'(1);
      if (tpop)  trp <= trp + (AW+1)'(1);
    end

  // During BIST the pattern bytes replace the FIFO as the source and CTS is ignored.
  assign bist_pend = bist_busy && !bist_txi[2];
  assign tx_avail  = bist_busy ? bist_pend : (!tx_empty && CTS);
  assign tx_next   = bist_busy ? DATA_BITS'(bist_pattern(bist_txi[1:0])) : tmem[trp[AW-1:0]];
  assign tx_load   = tick && tx_avail &&
                     (ts == TX_IDLE || (ts == TX_STOP && tcnt == BW'(STOP_BITS - 1)));

  always_ff @(posedge SysClk or negedge Rst)
    if (!Rst) begin
      ts     <= TX_IDLE;
      tx_bit <= 1'b1;
      tsh    <= '0;
      tpar   <= 1'b0;
      tcnt   <= '0;
    end else if (tx_load) begin
      ts     <= TX_START;
      tx_bit <= 1'b0;
      tsh    <= tx_next;
      tpar   <= ^tx_next;
    end else if (tick) begin
      case (ts)
        TX_START: begin
          ts     <= TX_DATA;
          tx_bit <= tsh[DATA_BITS-1];
          tcnt   <= '0;
        end
        TX_DATA:
          if (tcnt == BW'(DATA_BITS - 1)) begin
            tcnt   <= '0;
            ts     <= (PARITY_BIT != 0) ? TX_PARITY : TX_STOP;
            tx_bit <= (PARITY_BIT != 0) ? tpar : 1'b1;
          end else begin
            tcnt   <= tcnt + BW'(1);
            tsh    <= tsh << 1;
            tx_bit <= tsh[DATA_BITS-2];
          end
        TX_PARITY: begin
          ts     <= TX_STOP;
          tx_bit <= 1'b1;
          tcnt   <= '0;
        end
        TX_STOP:
          if (tcnt == BW'(STOP_BITS - 1)) ts <= TX_IDLE;
          else                            tcnt <= tcnt + BW'(1);
        default: ts <= TX_IDLE;
      endcase
    end

  logic                 rs1, rs2, rx_src, rx_prev, rsample, rx_fin, fin_ferr, rperr, rferr;
  rx_state_t            rs;
  logic [CW-1:0]        rcnt;
  logic [BW-1:0]        rbcnt;
  logic [DATA_BITS-1:0] rsh;

  assign rx_src   = bist_busy ? tx_bit : rs2;
  assign rsample  = (rs == RX_START) ? (rcnt == CW'(HALF)) : (rcnt == CW'(BDIV - 1));
  assign rx_fin   = (rs == RX_STOP) && rsample && (rbcnt == BW'(STOP_BITS - 1));
  assign fin_ferr = rferr || !rx_src;

  always_ff @(posedge SysClk or negedge Rst)
    if (!Rst) begin
      rs1     <= 1'b1;
      rs2     <= 1'b1;
      rx_prev <= 1'b1;
      rs      <= RX_IDLE;
      rcnt    <= '0;
      rbcnt   <= '0;
      rsh     <= '0;
      rperr   <= 1'b0;
      rferr   <= 1'b0;
    end else begin
      rs1     <= Rx;
      rs2     <= rs1;
      rx_prev <= rx_src;
      if (rs == RX_IDLE) begin
        rcnt <= '0;
        if (rx_prev && !rx_src) begin
          rs    <= RX_START;
          rperr <= 1'b0;
          rferr <= 1'b0;
        end
      end else begin
        rcnt <= rsample ? '0 : rcnt + CW'(1);
        if (rsample)
          case (rs)
            RX_START:
              if (rx_src) rs <= RX_IDLE;
              else begin
                rs    <= RX_DATA;
                rbcnt <= '0;
              end
            RX_DATA: begin
              rsh <= {rsh[DATA_BITS-2:0], rx_src};
              if (rbcnt == BW'(DATA_BITS - 1)) begin
                rbcnt <= '0;
                rs    <= (PARITY_BIT != 0) ? RX_PARITY : RX_STOP;
              end else rbcnt <= rbcnt + BW'(1);
            end
            RX_PARITY: begin
              rperr <= rx_src ^ (^rsh);
              rs    <= RX_STOP;
            end
            RX_STOP: begin
              if (!rx_src) rferr <= 1'b1;
              if (rbcnt == BW'(STOP_BITS - 1)) rs <= RX_IDLE;
              else                              rbcnt <= rbcnt + BW'(1);
            end
            default: rs <= RX_IDLE;
          endcase
      end
    end

  logic [DATA_BITS-1:0] rmem [FIFO_DEPTH];
  logic [AW:0]          rwp, rrp;
  logic                 rx_empty, rx_full, rpush, rpop;
  rx_err_t              rerr;

  assign rx_empty = (rwp == rrp);
  assign rx_full  = (rwp[AW] != rrp[AW]) && (rwp[AW-1:0] == rrp[AW-1:0]);
  assign rpop     = Rd_En && !rx_empty;
  assign rpush    = rx_fin && !bist_busy && (!rx_full || rpop);

  always_ff @(posedge SysClk) if (rpush) rmem[rwp[AW-1:0]] <= rsh;

  always_ff @(posedge SysClk or negedge Rst)
    if (!Rst) begin
      rwp  <= '0;
      rrp  <= '0;
      rerr <= '0;
    end else begin
      if (rpush) rwp <= rwp + (AW+1)'(1);
      if (rpop)  rrp <= rrp + (AW+1)'(1);
      if (Rd_En) rerr <= '0;
      // A new error in the same cycle as a read wins over the clear.
      if (rx_fin && !bist_busy) begin
        if (rperr)              rerr.parity  <= 1'b1;
        if (fin_ferr)           rerr.framing <= 1'b1;
        if (rx_full && !rpop)   rerr.overrun <= 1'b1;
      end
    end

  assign bist_go = BIST_Start && !bist_busy && (ts == TX_IDLE) && !tx_load;

  always_ff @(posedge SysClk or negedge Rst)
    if (!Rst) begin
      bist_busy <= 1'b0;
      bist_err  <= 1'b0;
      bist_fin  <= 1'b0;
      bist_txi  <= '0;
      bist_rxi  <= '0;
    end else if (bist_go) begin
      bist_busy <= 1'b1;
      bist_err  <= 1'b0;
      bist_fin  <= 1'b0;
      bist_txi  <= '0;
      bist_rxi  <= '0;
    end else if (bist_busy) begin
      if (tx_load) bist_txi <= bist_txi + 3'd1;
      if (bist_fin) begin
        bist_busy <= 1'b0;
        bist_fin  <= 1'b0;
      end else if (rx_fin) begin
        if (rsh != DATA_BITS'(bist_pattern(bist_rxi)) || rperr || fin_ferr) bist_err <= 1'b1;
        bist_rxi <= bist_rxi + 2'd1;
        if (bist_rxi == 2'd3) bist_fin <= 1'b1;
      end
    end

  assign Tx         = tx_bit | bist_busy;
  assign Tx_Full    = tx_full;
  assign FIFO_Empty = tx_empty;
  assign Data_Rdy   = !rx_empty;
  assign Rx_Data    = rx_empty ? '0 : rmem[rrp[AW-1:0]];
  assign Rx_Error   = rerr;
  assign RTS        = !rx_full;
  assign BIST_Busy  = bist_busy;
  assign BIST_Error = bist_err;
endmodule

// File: tb/tb_uart_sv.sv
// Randomised bench for uart_sv against a frame-level reference model (bit lists and a byte queue).
module tb_uart_sv;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int D  = DIV;
  localparam int FB = FRAME_BITS;

  logic          SysClk = 1'b0, Rst = 1'b0;
  logic          Wr_En = 1'b0, Rd_En = 1'b0, BIST_Start = 1'b0, Rx = 1'b1, CTS = 1'b1;
  logic [DW-1:0] Wr_Data = '0;
  logic [DW-1:0] Rx_Data;
  logic [2:0]    Rx_Error;
  logic          Tx_Full, FIFO_Empty, Data_Rdy, BIST_Busy, BIST_Error, Tx, RTS;

  int n_chk = 0, n_pass = 0;

  always #5 SysClk = ~SysClk;

  uart_sv dut (
    .SysClk(SysClk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Data(Wr_Data), .Tx_Full(Tx_Full),
    .FIFO_Empty(FIFO_Empty), .Rd_En(Rd_En), .Rx_Data(Rx_Data), .Data_Rdy(Data_Rdy),
    .Rx_Error(Rx_Error), .BIST_Start(BIST_Start), .BIST_Busy(BIST_Busy),
    .BIST_Error(BIST_Error), .Rx(Rx), .Tx(Tx), .CTS(CTS), .RTS(RTS)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference frame: start 0, data MSB first, even parity, then stop ones.
  function automatic logic frame_bit(input logic [DW-1:0] d, input int i);
    if (i == 0)      return 1'b0;
    if (i <= DW)     return d[DW-i];
    if (i == DW + 1) return ($countones(d) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic wr(input logic [DW-1:0] d);
    Wr_Data = d; Wr_En = 1'b1;
    @(negedge SysClk);
    Wr_En = 1'b0;
  endtask

  task automatic rd();
    Rd_En = 1'b1;
    @(negedge SysClk);
    Rd_En = 1'b0;
  endtask

  task automatic wait_start(input int bound, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge SysClk);
      if (Tx === 1'b0) begin ok = 1'b1; break; end
    end
    chk({tag, "_start"}, 32'(ok), 32'd1);
  endtask

  // Entered on the first cycle of the start bit; every cycle of every bit is compared.
  task automatic chk_frame(input logic [DW-1:0] d, input string tag);
    for (int i = 0; i < FB; i++)
      for (int j = 0; j < D; j++) begin
        chk($sformatf("%s_bit%0d", tag, i), 32'(Tx), 32'(frame_bit(d, i)));
        @(negedge SysClk);
      end
  endtask

  task automatic send_rx(input logic [DW-1:0] d, input bit bad_par, input int bad_stop);
    logic b;
    for (int i = 0; i < FB; i++) begin
      b = frame_bit(d, i);
      if (i == DW + 1 && bad_par) b = ~b;
      if (bad_stop >= 0 && i == DW + 2 + bad_stop) b = 1'b0;
      Rx = b;
      repeat (D) @(negedge SysClk);
    end
    Rx = 1'b1;
    repeat (3) @(negedge SysClk);
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] d;
  bit            ok, hi;
  int            busy_n;

  initial begin
    repeat (3) @(negedge SysClk);
    chk("rst_tx", 32'(Tx), 1);           chk("rst_rts", 32'(RTS), 1);
    chk("rst_full", 32'(Tx_Full), 0);    chk("rst_empty", 32'(FIFO_Empty), 1);
    chk("rst_rdy", 32'(Data_Rdy), 0);    chk("rst_rxdata", 32'(Rx_Data), 0);
    chk("rst_err", 32'(Rx_Error), 0);    chk("rst_bbusy", 32'(BIST_Busy), 0);
    chk("rst_berr", 32'(BIST_Error), 0);
    Rst = 1'b1;
    repeat (2) @(negedge SysClk);

    wr(8'hBB);
    wait_start(3 * D, "bb", ok);
    if (ok) chk_frame(8'hBB, "bb");
    chk("bb_empty", 32'(FIFO_Empty), 1);

    CTS = 1'b0; d = DW'($urandom_range(0, 255));
    wr(d);
    chk("cts_queued", 32'(FIFO_Empty), 0);
    hi = 1'b1;
    repeat (5 * D) begin @(negedge SysClk); if (Tx !== 1'b1) hi = 1'b0; end
    chk("cts_hold", 32'(hi), 1);
    CTS = 1'b1;
    wait_start(D, "cts_rise", ok);
    if (ok) chk_frame(d, "cts");

    CTS = 1'b0; q = {};
    for (int k = 0; k < 8; k++) begin
      d = DW'($urandom_range(0, 255)); q.push_back(d); wr(d);
    end
    chk("txq_full", 32'(Tx_Full), 1);
    wr(DW'($urandom_range(0, 255)));
    chk("txq_full_drop", 32'(Tx_Full), 1);
    CTS = 1'b1;
    wait_start(D, "txq", ok);
    if (ok) foreach (q[k]) chk_frame(q[k], $sformatf("txq%0d", k));
    chk("txq_drained", 32'(FIFO_Empty), 1);

    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 8'hAA : DW'($urandom_range(0, 255));
      send_rx(d, 1'b0, -1);
      chk("rx_rdy", 32'(Data_Rdy), 1);
      chk("rx_data", 32'(Rx_Data), 32'(d));
      chk("rx_err", 32'(Rx_Error), 0);
      rd();
      chk("rx_popped", 32'(Data_Rdy), 0);
    end

    d = DW'($urandom_range(0, 255));
    send_rx(d, 1'b1, -1);
    chk("par_err", 32'(Rx_Error), 32'b001);
    chk("par_data", 32'(Rx_Data), 32'(d));
    rd();
    chk("par_clr", 32'(Rx_Error), 0);

    d = DW'($urandom_range(0, 255));
    send_rx(d, 1'b0, int'($urandom_range(0, 1)));
    chk("frm_err", 32'(Rx_Error), 32'b010);
    chk("frm_data", 32'(Rx_Data), 32'(d));
    rd();
    chk("frm_clr", 32'(Rx_Error), 0);

    Rx = 1'b0; @(negedge SysClk); Rx = 1'b1;
    repeat (FB * D) @(negedge SysClk);
    chk("glitch_rdy", 32'(Data_Rdy), 0);
    chk("glitch_err", 32'(Rx_Error), 0);

    q = {};
    for (int k = 1; k <= 9; k++) begin
      d = DW'($urandom_range(0, 255));
      if (q.size() < 8) q.push_back(d);
      send_rx(d, 1'b0, -1);
      chk($sformatf("rts_after%0d", k), 32'(RTS), 32'(q.size() < 8));
    end
    chk("ovr_err", 32'(Rx_Error), 32'b100);
    foreach (q[k]) begin
      chk($sformatf("ovr_rdy%0d", k), 32'(Data_Rdy), 1);
      chk($sformatf("ovr_data%0d", k), 32'(Rx_Data), 32'(q[k]));
      rd();
      if (k == 0) chk("ovr_clr", 32'(Rx_Error), 0);
    end
    chk("ovr_empty", 32'(Data_Rdy), 0);

    CTS = 1'b0;
    BIST_Start = 1'b1; @(negedge SysClk); BIST_Start = 1'b0;
    chk("bist_busy", 32'(BIST_Busy), 1);
    d = DW'($urandom_range(0, 255));
    wr(d);
    busy_n = 2; hi = 1'b1;
    while (BIST_Busy === 1'b1 && busy_n < 400) begin
      if (Tx !== 1'b1) hi = 1'b0;
      @(negedge SysClk); busy_n++;
    end
    chk("bist_done", 32'(BIST_Busy), 0);
    chk("bist_len", 32'(busy_n >= 4 * FB * D - 2 * D && busy_n <= 4 * FB * D + 2 * D), 1);
    chk("bist_tx_held", 32'(hi), 1);
    chk("bist_err", 32'(BIST_Error), 0);
    chk("bist_no_rx", 32'(Data_Rdy), 0);
    chk("bist_host_queued", 32'(FIFO_Empty), 0);
    hi = 1'b1;
    repeat (2 * D) begin @(negedge SysClk); if (Tx !== 1'b1) hi = 1'b0; end
    chk("bist_post_hold", 32'(hi), 1);
    CTS = 1'b1;
    wait_start(3 * D, "post_bist", ok);
    if (ok) chk_frame(d, "post_bist");

    wr(DW'($urandom_range(0, 255)));
    wr(DW'($urandom_range(0, 255)));
    wait_start(3 * D, "rst_mid", ok);
    repeat (2 * D) @(negedge SysClk);
    Rst = 1'b0; #1;
    chk("rstmid_tx", 32'(Tx), 1);
    chk("rstmid_empty", 32'(FIFO_Empty), 1);
    chk("rstmid_full", 32'(Tx_Full), 0);
    @(negedge SysClk); Rst = 1'b1;
    hi = 1'b1;
    repeat (FB * D) begin @(negedge SysClk); if (Tx !== 1'b1) hi = 1'b0; end
    chk("rstmid_discard", 32'(hi), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
